// File: rtl/memory_bank_scheduler.sv
// memory_bank_scheduler: admission, occupancy tracking and round-robin read
// selection for the shared per-VC flit bank of one input port.
module memory_bank_scheduler #(
  parameter int max_vc_number     = 10,
  parameter int memory_bank_depth = 32,
  parameter int max_flits_per_vc  = 16,
  localparam int cnt_width = $clog2(memory_bank_depth + 1),
  localparam int ptr_width = (max_vc_number > 1) ? $clog2(max_vc_number) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr_req,
  input  logic [0:max_vc_number-1]             wr_vc,
  output logic                                 wr_accept,
  input  logic [0:max_vc_number-1]             rd_ready,
  output logic                                 write_enable,
  output logic [0:max_vc_number-1]             vc_written_into,
  output logic                                 read_enable,
  output logic [0:max_vc_number-1]             vc_read_from,
  output logic                                 flit_out_valid,
  output logic [0:max_vc_number-1]             flit_out_vc,
  output logic [0:max_vc_number*cnt_width-1]   vc_count,
  output logic [0:max_vc_number-1]             vc_nonempty,
  output logic                                 bank_full,
  output logic                                 bank_empty
);

  logic [cnt_width-1:0] count [max_vc_number];
  logic [cnt_width-1:0] total_count;
  logic [ptr_width-1:0] rr_ptr;
  logic [0:max_vc_number-1] elig;
  logic [0:max_vc_number-1] grant;
  logic [ptr_width-1:0] grant_idx;
  logic                 grant_found;
  logic [cnt_width-1:0] wr_target_count;
  logic                 wr_vc_onehot;

  // True when exactly one bit of the VC vector is set.
  function automatic logic is_onehot(input logic [0:max_vc_number-1] vec);
    int ones;
    ones = 0;
    for (int i = 0; i < max_vc_number; i++) ones += int'(vec[i]);
    return (ones == 1);
  endfunction

  // Status flags and the packed occupancy view, VC0 in the leftmost slice.
  always_comb begin
    vc_count    = '0;
    vc_nonempty = '0;
    for (int v = 0; v < max_vc_number; v++) begin
      vc_count[v*cnt_width +: cnt_width] = count[v];
      vc_nonempty[v] = (count[v] != '0);
    end
    bank_full  = (total_count == cnt_width'(memory_bank_depth));
    bank_empty = (total_count == '0);
  end

  // Write admission: one-hot target, room in the bank and under the VC cap.
  always_comb begin
    wr_target_count = '0;
    for (int v = 0; v < max_vc_number; v++)
      if (wr_vc[v]) wr_target_count = wr_target_count | count[v];
    wr_vc_onehot    = is_onehot(wr_vc);
    write_enable    = reset & wr_req & wr_vc_onehot & ~bank_full &
                      (wr_target_count < cnt_width'(max_flits_per_vc));
    wr_accept       = write_enable;
    vc_written_into = write_enable ? wr_vc : '0;
  end

  // Round-robin pick of the first eligible VC at or after rr_ptr.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int v = 0; v < max_vc_number; v++)
      elig[v] = (count[v] != '0) & rd_ready[v];
    for (int i = 0; i < max_vc_number; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= max_vc_number) idx = idx - max_vc_number;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ptr_width'(idx);
      end
    end
    read_enable  = reset & grant_found;
    vc_read_from = reset ? grant : '0;
  end

  // Occupancy counters, arbitration pointer and the read-data tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < max_vc_number; v++) count[v] <= '0;
      total_count    <= '0;
      rr_ptr         <= '0;
      flit_out_valid <= 1'b0;
      flit_out_vc    <= '0;
    end else begin
      for (int v = 0; v < max_vc_number; v++) begin
        case ({vc_written_into[v], vc_read_from[v]})
          2'b10:   count[v] <= count[v] + 1'b1;
          2'b01:   count[v] <= count[v] - 1'b1;
          default: count[v] <= count[v];
        endcase
      end
      case ({write_enable, read_enable})
        2'b10:   total_count <= total_count + 1'b1;
        2'b01:   total_count <= total_count - 1'b1;
        default: total_count <= total_count;
      endcase
      if (read_enable)
        rr_ptr <= (grant_idx == ptr_width'(max_vc_number - 1)) ? '0 : grant_idx + 1'b1;
      flit_out_valid <= read_enable;
      flit_out_vc    <= vc_read_from;
    end
  end

endmodule

// File: tb/tb_memory_bank_scheduler.sv
// Directed bench for memory_bank_scheduler: two instances share stimulus,
// one with the default per-VC cap of 16 and one with a cap of 32.
module tb_memory_bank_scheduler;

  localparam int NVC = 10;
  localparam int CW  = 6;

  logic clk = 1'b0;
  logic reset;
  logic wr_req;
  logic [0:NVC-1] wr_vc;
  logic [0:NVC-1] rd_ready;

  logic wr_accept, write_enable, read_enable, flit_out_valid, bank_full, bank_empty;
  logic [0:NVC-1] vc_written_into, vc_read_from, flit_out_vc, vc_nonempty;
  logic [0:NVC*CW-1] vc_count;

  logic wr_accept32, write_enable32, read_enable32, flit_out_valid32, bank_full32, bank_empty32;
  logic [0:NVC-1] vc_written_into32, vc_read_from32, flit_out_vc32, vc_nonempty32;
  logic [0:NVC*CW-1] vc_count32;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  memory_bank_scheduler dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_vc(wr_vc), .wr_accept(wr_accept),
    .rd_ready(rd_ready), .write_enable(write_enable), .vc_written_into(vc_written_into),
    .read_enable(read_enable), .vc_read_from(vc_read_from), .flit_out_valid(flit_out_valid),
    .flit_out_vc(flit_out_vc), .vc_count(vc_count), .vc_nonempty(vc_nonempty),
    .bank_full(bank_full), .bank_empty(bank_empty)
  );

  memory_bank_scheduler #(.max_flits_per_vc(32)) dut32 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_vc(wr_vc), .wr_accept(wr_accept32),
    .rd_ready(rd_ready), .write_enable(write_enable32), .vc_written_into(vc_written_into32),
    .read_enable(read_enable32), .vc_read_from(vc_read_from32), .flit_out_valid(flit_out_valid32),
    .flit_out_vc(flit_out_vc32), .vc_count(vc_count32), .vc_nonempty(vc_nonempty32),
    .bank_full(bank_full32), .bank_empty(bank_empty32)
  );

  always #5 clk = ~clk;

  function automatic logic [0:NVC-1] oh(input int v);
    logic [0:NVC-1] r;
    r = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  function automatic logic [CW-1:0] get_cnt(input logic [0:NVC*CW-1] vec, input int v);
    return vec[v*CW +: CW];
  endfunction

  function automatic int cnt_sum(input logic [0:NVC*CW-1] vec);
    int s;
    s = 0;
    for (int v = 0; v < NVC; v++) s += int'(vec[v*CW +: CW]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold reset for one edge while a write and all readies are offered.
  task automatic do_reset();
    reset = 1'b0; wr_req = 1'b1; wr_vc = oh(2); rd_ready = '1;
    #1;
    chk("rst_wr_accept", 64'(wr_accept), 64'd0);
    chk("rst_read_enable", 64'(read_enable), 64'd0);
    chk("rst_vc_read_from", 64'(vc_read_from), 64'd0);
    tick();
    reset = 1'b1; wr_req = 1'b0; wr_vc = '0; rd_ready = '0;
    #1;
    chk("rst_vc_count", 64'(vc_count), 64'd0);
    chk("rst_vc_nonempty", 64'(vc_nonempty), 64'd0);
    chk("rst_bank_empty", 64'(bank_empty), 64'd1);
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    chk("rst_flit_out_valid", 64'(flit_out_valid), 64'd0);
    chk("rst_flit_out_vc", 64'(flit_out_vc), 64'd0);
    chk("rst_vc_count32", 64'(vc_count32), 64'd0);
  endtask

  // Occupancy flags must agree with the sum of per-VC counts every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_bank_empty", 64'(bank_empty), 64'(cnt_sum(vc_count) == 0));
      chk("inv_bank_full", 64'(bank_full), 64'(cnt_sum(vc_count) == 32));
    end
  end

  initial begin
    int exp_g [6];
    reset = 1'b0; wr_req = 1'b0; wr_vc = '0; rd_ready = '0;
    tick();
    do_reset();
    mon_en = 1'b1;

    // 32 writes to VC3 fill the cap-32 instance; the 33rd is refused.
    for (int i = 0; i < 32; i++) begin
      wr_req = 1'b1; wr_vc = oh(3);
      #1;
      chk($sformatf("fill32_accept_%0d", i), 64'(wr_accept32), 64'd1);
      tick();
    end
    #1;
    chk("fill32_bank_full", 64'(bank_full32), 64'd1);
    chk("fill32_cnt3", 64'(get_cnt(vc_count32, 3)), 64'd32);
    chk("fill32_reject", 64'(wr_accept32), 64'd0);
    chk("fill32_wr_into", 64'(vc_written_into32), 64'd0);
    tick();
    chk("fill32_cnt3_hold", 64'(get_cnt(vc_count32, 3)), 64'd32);
    chk("cap16_cnt3", 64'(get_cnt(vc_count, 3)), 64'd16);

    // Default cap: 16 writes to VC0 accepted, 17th refused while not full.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1; wr_vc = oh(0);
      #1;
      chk($sformatf("cap16_accept_%0d", i), 64'(wr_accept), 64'd1);
      tick();
    end
    #1;
    chk("cap16_reject", 64'(wr_accept), 64'd0);
    chk("cap16_bank_full", 64'(bank_full), 64'd0);
    chk("cap16_cnt0", 64'(get_cnt(vc_count, 0)), 64'd16);
    wr_vc = 10'b1100000000;
    #1;
    chk("multihot_reject", 64'(write_enable32), 64'd0);
    wr_vc = '0;
    #1;
    chk("zero_vc_reject", 64'(write_enable32), 64'd0);

    // Two flits each in VC1, VC4, VC9, then drain with all ready.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_req = 1'b1; wr_vc = oh((i < 2) ? 1 : (i < 4) ? 4 : 9);
      tick();
    end
    wr_req = 1'b0; wr_vc = '0; rd_ready = '1;
    exp_g = '{1, 4, 9, 1, 4, 9};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_grant_%0d", k), 64'(vc_read_from), 64'(oh(exp_g[k])));
      chk($sformatf("rr_rden_%0d", k), 64'(read_enable), 64'd1);
      if (k > 0) begin
        chk($sformatf("rr_tag_%0d", k), 64'(flit_out_vc), 64'(oh(exp_g[k-1])));
        chk($sformatf("rr_tagv_%0d", k), 64'(flit_out_valid), 64'd1);
      end
      tick();
    end
    #1;
    chk("rr_tag_last", 64'(flit_out_vc), 64'(oh(9)));
    chk("rr_bank_empty", 64'(bank_empty), 64'd1);
    chk("rr_idle", 64'(read_enable), 64'd0);

    // Write into empty VC2 is not readable in the same cycle.
    tick();
    wr_req = 1'b1; wr_vc = oh(2);
    #1;
    chk("lat_wr_accept", 64'(wr_accept), 64'd1);
    chk("lat_wr_into", 64'(vc_written_into), 64'(oh(2)));
    chk("lat_no_grant", 64'(read_enable), 64'd0);
    tick();
    wr_req = 1'b0; wr_vc = '0;
    #1;
    chk("lat_grant", 64'(vc_read_from), 64'(oh(2)));
    chk("lat_tagv_early", 64'(flit_out_valid), 64'd0);
    tick();
    #1;
    chk("lat_tagv", 64'(flit_out_valid), 64'd1);
    chk("lat_tag", 64'(flit_out_vc), 64'(oh(2)));
    chk("lat_empty", 64'(bank_empty), 64'd1);

    // VC5 holds one flit; write and read it together for ten cycles.
    rd_ready = '0; wr_req = 1'b1; wr_vc = oh(5);
    tick();
    rd_ready = oh(5);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("rw_wr_%0d", i), 64'(wr_accept), 64'd1);
      chk($sformatf("rw_rd_%0d", i), 64'(vc_read_from), 64'(oh(5)));
      tick();
      chk($sformatf("rw_cnt5_%0d", i), 64'(get_cnt(vc_count, 5)), 64'd1);
      chk($sformatf("rw_total_%0d", i), 64'(cnt_sum(vc_count)), 64'd1);
    end
    wr_req = 1'b0; wr_vc = '0; rd_ready = '0;

    // Seven flits in flight, then reset; pointer must restart at VC0.
    for (int i = 0; i < 6; i++) begin
      wr_req = 1'b1; wr_vc = oh((i < 2) ? 0 : (i < 4) ? 7 : 8);
      tick();
    end
    #1;
    chk("pre_rst_total", 64'(cnt_sum(vc_count)), 64'd7);
    do_reset();
    wr_req = 1'b1; wr_vc = oh(7);
    tick();
    wr_vc = oh(0);
    tick();
    wr_req = 1'b0; wr_vc = '0; rd_ready = '1;
    #1;
    chk("post_rst_grant", 64'(vc_read_from), 64'(oh(0)));
    tick();
    #1;
    chk("post_rst_grant2", 64'(vc_read_from), 64'(oh(7)));
    rd_ready = '0;
    tick();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_bank_scheduler.md
# memory_bank_scheduler

Controller for the shared, dynamically allocated per-VC memory bank of an input port. It admits incoming flits into the bank and keeps per-VC and total occupancy counters. Each cycle it picks at most one VC to read, using round-robin among VCs that are non-empty and whose downstream is ready. It drives the bank's one-hot VC selects and write/read enables, and tags the bank's registered read data one cycle later.

## Interface
- max_vc_number, 10, number of VCs sharing the bank
- memory_bank_depth, 32, bank capacity in flits
- max_flits_per_vc, 16, per-VC occupancy cap, 1..memory_bank_depth
- Derived: cnt_width = clogb(memory_bank_depth+1)

- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-low reset
- wr_req  in  1  incoming flit valid
- wr_vc  in  [0:max_vc_number-1]  one-hot target VC of incoming flit
- wr_accept  out  1  flit accepted this cycle; equals write_enable
- rd_ready  in  [0:max_vc_number-1]  per-VC downstream ready (credit available)
- write_enable  out  1  bank write strobe
- vc_written_into  out  [0:max_vc_number-1]  one-hot write VC; equals wr_vc when write_enable, else 0
- read_enable  out  1  bank read strobe
- vc_read_from  out  [0:max_vc_number-1]  one-hot read grant, 0 when idle
- flit_out_valid  out  1  bank flit_out valid (registered)
- flit_out_vc  out  [0:max_vc_number-1]  one-hot VC of flit_out (registered)
- vc_count  out  [0:max_vc_number*cnt_width-1]  per-VC occupancy, VC0 in MSB slice
- vc_nonempty  out  [0:max_vc_number-1]  count != 0 per VC
- bank_full  out  1  total_count == memory_bank_depth
- bank_empty  out  1  total_count == 0

## Operation
- State: vc_count[v] (cnt_width), total_count (cnt_width), rr_ptr (clogb(max_vc_number)), flit_out_valid, flit_out_vc.
- Write admission (combinational): write_enable = reset & wr_req & onehot(wr_vc) & !bank_full & count[wr_vc] < max_flits_per_vc.
  - A non-one-hot wr_vc (zero or multi-bit) is rejected.
  - Fullness uses registered counts only. There is no read-to-write bypass, so a full bank rejects a write even in a cycle where a read occurs.
- Read eligibility: elig[v] = (vc_count[v] != 0) & rd_ready[v].
  - A flit written this cycle is not readable until the next cycle; the bank's link pointers update on the write edge.
- Arbitration: round-robin starting at rr_ptr, wrapping from max_vc_number-1 to 0.
  - read_enable = reset & |elig; vc_read_from = one-hot of the first eligible VC at or after rr_ptr.
  - On a grant to VC g, rr_ptr <= (g == max_vc_number-1) ? 0 : g+1. With no grant, rr_ptr holds.
- Counter update per cycle:
  - vc_count[v] += (write to v) - (read from v).
  - total_count += write_enable - read_enable.
  - A simultaneous write and read on the same VC leaves that count unchanged. Counts never wrap, since admission and eligibility forbid it.
- Output tag: flit_out_valid <= read_enable; flit_out_vc <= vc_read_from.
- Reset (reset==0 at a clk edge):
  - All counts clear to 0, rr_ptr clears to 0, flit_out_valid clears to 0, flit_out_vc clears to 0.
  - While reset is low, write_enable, read_enable, wr_accept and both one-hot selects are forced to 0 combinationally.
  - Mid-operation reset discards all occupancy. The bank is reset on the same edge.

## Timing
- Admission and grant are combinational from registered state plus inputs, in the same cycle as wr_req/rd_ready.
- Write-to-readable latency: 1 cycle. A flit written at edge N is eligible during cycle N+1.
- Read latency: the bank flit_out is registered, so flit_out_valid/flit_out_vc assert on the edge after read_enable and align with flit_out.
- Throughput: 1 write plus 1 read per cycle sustained.
- Reset values: write_enable=0, read_enable=0, wr_accept=0, vc_written_into=0, vc_read_from=0, flit_out_valid=0, flit_out_vc=0, vc_count=0, vc_nonempty=0, bank_full=0, bank_empty=1.
- Invariant: total_count == sum of vc_count[v] at every edge. The bench asserts this every cycle.

## Test plan
- Reset, then 32 consecutive writes to VC3 with max_flits_per_vc=32 and all rd_ready=0 -> wr_accept high for 32 cycles; bank_full=1 after the 32nd edge; the 33rd wr_req is rejected with wr_accept=0 and counts unchanged.
- Default cap 16, writes to VC0 only -> 16 accepted, 17th rejected while bank_full=0 and vc_count[VC0]=16.
- VC1, VC4 and VC9 each hold 2 flits, all rd_ready=1 -> grants VC1, VC4, VC9, VC1, VC4, VC9; flit_out_vc follows each grant one cycle later; bank_empty=1 after the 6th read.
- VC2 empty, write to VC2 at cycle N with rd_ready[2]=1 -> no grant at N; grant to VC2 at N+1; flit_out_valid at N+2.
- VC5 holds 1 flit; simultaneous write and read on VC5 for 10 cycles -> vc_count[VC5] stays 1 and total_count is constant.
- Fill 7 flits across VCs, assert reset=0 for one edge with wr_req=1 -> wr_accept=0 and read_enable=0 during reset; afterwards all counts are 0, bank_empty=1, and the first grant starts search at VC0.
